// File: rtl/lighthouse_report_arbiter_pkg.sv
// lighthouse_pkg: shared constants and record-tag helper for the lighthouse report path.
package lighthouse_pkg;
   localparam int SLOTS_PER_SENSOR = 4;
   localparam int MAX_SLOTS = 16;
   localparam logic [3:0] TAG_BASE = 4'hA;
   localparam int REC_W = 28;
   localparam logic [15:0] OVERRUN_MAX = 16'hFFFF;
   function automatic logic [7:0] make_tag(input logic [3:0] slot);
      return {TAG_BASE + {2'b00, slot[3:2]}, {2'b00, slot[1:0]}};
   endfunction
endpackage

// File: rtl/lighthouse_report_arbiter_if.sv
// lighthouse_report_arbiter_if: valid/ready record stream toward the timer FIFO.
interface lighthouse_report_arbiter_if #(parameter int W = 28) ();
   logic [W-1:0] data;
   logic valid;
   logic ready;
   modport master (output data, output valid, input ready);
   modport slave (input data, input valid, output ready);
endinterface

// File: rtl/lighthouse_report_arbiter_rr_picker.sv
// rr_picker: combinational round-robin search, first request at or after ptr, wrapping.
module rr_picker #(
   parameter int N = 16,
   localparam int W = $clog2(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic         found,
   output logic [W-1:0] idx
);
   always_comb begin
      found = 1'b0;
      idx = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[(int'(ptr) + i) % N]) begin
            found = 1'b1;
            idx = W'((int'(ptr) + i) % N);
         end
      end
   end
endmodule

// File: rtl/lighthouse_report_arbiter.sv
// lighthouse_report_arbiter: per-slot angle holding registers drained round-robin to one FIFO port.
// Define LIGHTHOUSE_ARB_OVERRUN_EN to build the saturating overrun counter.
module lighthouse_report_arbiter
   import lighthouse_pkg::*;
#(
   parameter int NUM_SENSORS = 4,
   parameter int ANGLE_WIDTH = 20,
   parameter int TAG_WIDTH = 8,
   localparam int S = NUM_SENSORS * SLOTS_PER_SENSOR
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [S*ANGLE_WIDTH-1:0]   angle_in,
   input  logic [S-1:0]               strobe_in,
   lighthouse_report_arbiter_if.master out,
   output logic [S-1:0]               pending,
   output logic [15:0]                overrun_count
);
   logic [MAX_SLOTS-1:0] pend_q, pend_d;
   logic [ANGLE_WIDTH-1:0] hold_q [MAX_SLOTS];
   logic [ANGLE_WIDTH-1:0] hold_d [MAX_SLOTS];
   logic [3:0] rr_q, rr_d, win;
   logic found, grant, full_q, full_d;
   logic [TAG_WIDTH+ANGLE_WIDTH-1:0] data_q, data_d;

   rr_picker #(.N(MAX_SLOTS)) u_pick (.req(pend_q), .ptr(rr_q), .found(found), .idx(win));

   assign grant = found & (~full_q | out.ready);

   // A grant reads the old hold value; a same-edge strobe re-arms the slot.
   always_comb begin
      pend_d = pend_q;
      hold_d = hold_q;
      if (grant) pend_d[win] = 1'b0;
      for (int k = 0; k < S; k++) begin
         if (strobe_in[k]) begin
            pend_d[k] = 1'b1;
            hold_d[k] = angle_in[k*ANGLE_WIDTH +: ANGLE_WIDTH];
         end
      end
      full_d = grant | (full_q & ~out.ready);
      data_d = grant ? {TAG_WIDTH'(make_tag(win)), hold_q[win]} : data_q;
      rr_d = grant ? win + 4'd1 : rr_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pend_q <= '0;
         rr_q <= '0;
         full_q <= 1'b0;
         data_q <= '0;
      end else begin
         pend_q <= pend_d;
         rr_q <= rr_d;
         full_q <= full_d;
         data_q <= data_d;
      end
   end

   always_ff @(posedge clk) hold_q <= hold_d;

   assign out.valid = full_q;
   assign out.data = data_q;
   assign pending = pend_q[S-1:0];

`ifdef LIGHTHOUSE_ARB_OVERRUN_EN
   logic [4:0] n_ovr;
   logic [15:0] ovr_q, ovr_d;
   always_comb begin
      n_ovr = '0;
      for (int k = 0; k < S; k++)
         n_ovr = n_ovr + 5'(strobe_in[k] & pend_q[k] & ~(grant && win == 4'(k)));
      ovr_d = (OVERRUN_MAX - ovr_q < 16'(n_ovr)) ? OVERRUN_MAX : ovr_q + 16'(n_ovr);
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) ovr_q <= '0;
      else ovr_q <= ovr_d;
   end
   assign overrun_count = ovr_q;
`else
   assign overrun_count = '0;
`endif
endmodule

// File: tb/tb_lighthouse_report_arbiter.sv
// tb_lighthouse_report_arbiter: directed and random stimulus against a slot-level reference model.
module tb_lighthouse_report_arbiter;
   localparam int S = 16, AW = 20, RW = 28;

   logic clk = 1'b0;
   logic reset;
   logic [S*AW-1:0] angle_in;
   logic [S-1:0] strobe_in, pending;
   logic [15:0] overrun_count;
   int n_tests = 0, n_fail = 0;

   lighthouse_report_arbiter_if #(.W(RW)) bus ();

   lighthouse_report_arbiter dut (
      .clk(clk), .reset(reset), .angle_in(angle_in), .strobe_in(strobe_in),
      .out(bus), .pending(pending), .overrun_count(overrun_count)
   );

   always #5 clk = ~clk;

   bit m_pend [S];
   logic [AW-1:0] m_hold [S];
   int m_rr, m_cnt;
   bit m_full;
   logic [RW-1:0] m_data;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int exp_ovr();
`ifdef LIGHTHOUSE_ARB_OVERRUN_EN
      return m_cnt;
`else
      return 0;
`endif
   endfunction

   task automatic model_reset();
      for (int i = 0; i < S; i++) m_pend[i] = 1'b0;
      m_rr = 0; m_cnt = 0; m_full = 1'b0; m_data = '0;
   endtask

   task automatic model_step();
      int w = -1;
      bit g;
      bit old [S];
      logic [7:0] t;
      old = m_pend;
      for (int i = 0; i < S; i++) if (w < 0 && m_pend[(m_rr + i) % S]) w = (m_rr + i) % S;
      g = (!m_full || bus.ready) && w >= 0;
      if (m_full && bus.ready) m_full = 1'b0;
      if (g) begin
         t = {4'(10 + w / 4), 4'(w % 4)};
         m_data = {t, m_hold[w]};
         m_full = 1'b1;
         m_pend[w] = 1'b0;
         m_rr = (w + 1) % S;
      end
      for (int k = 0; k < S; k++) begin
         if (strobe_in[k]) begin
            if (old[k] && !(g && w == k)) m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
            m_hold[k] = angle_in[k*AW +: AW];
            m_pend[k] = 1'b1;
         end
      end
   endtask

   task automatic check_all();
      logic [S-1:0] mp;
      for (int i = 0; i < S; i++) mp[i] = m_pend[i];
      chk("valid", 32'(bus.valid), 32'(m_full));
      if (m_full) chk("data", 32'(bus.data), 32'(m_data));
      chk("pending", 32'(pending), 32'(mp));
      chk("overrun", 32'(overrun_count), 32'(exp_ovr()));
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      check_all();
   endtask

   task automatic strobe(input int k, input logic [AW-1:0] v);
      strobe_in[k] = 1'b1;
      angle_in[k*AW +: AW] = v;
   endtask

   // Asserts reset between edges and checks outputs clear without a clock.
   task automatic do_reset(input string tag);
      #2 reset = 1'b1;
      strobe_in = '0;
      #1;
      model_reset();
      chk({tag, "_valid"}, 32'(bus.valid), 32'd0);
      chk({tag, "_data"}, 32'(bus.data), 32'd0);
      chk({tag, "_pending"}, 32'(pending), 32'd0);
      chk({tag, "_ovr"}, 32'(overrun_count), 32'd0);
      #2 reset = 1'b0;
   endtask

   logic [RW-1:0] seq [4];

   initial begin
      reset = 1'b1;
      strobe_in = '0;
      angle_in = '0;
      bus.ready = 1'b0;
      model_reset();
      #2;
      chk("rst_valid", 32'(bus.valid), 32'd0);
      chk("rst_data", 32'(bus.data), 32'd0);
      chk("rst_pending", 32'(pending), 32'd0);
      #10 reset = 1'b0;

      bus.ready = 1'b1;
      strobe(5, 20'h12345);
      tick();
      strobe_in = '0;
      tick();
      chk("single_data", 32'(bus.data), 32'h0B112345);
      chk("single_valid", 32'(bus.valid), 32'd1);
      tick();
      chk("single_once", 32'(bus.valid), 32'd0);

      do_reset("r1");
      strobe(0, 20'd1); strobe(4, 20'd2); strobe(8, 20'd3); strobe(12, 20'd4);
      tick();
      strobe_in = '0;
      seq = '{28'hA000001, 28'hB000002, 28'hC000003, 28'hD000004};
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("burst_rec", 32'(bus.data), 32'(seq[i]));
      end
      tick();
      chk("burst_empty", 32'(pending), 32'd0);

      do_reset("r2");
      bus.ready = 1'b0;
      strobe(3, 20'h00333); strobe(7, 20'h00777); strobe(9, 20'h00999);
      tick();
      strobe_in = '0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("stall_data", 32'(bus.data), 32'h0A300333);
      end
      bus.ready = 1'b1;
      tick();
      chk("stall_rel1", 32'(bus.data), 32'h0B300777);
      tick();
      chk("stall_rel2", 32'(bus.data), 32'h0C100999);
      tick();

      do_reset("r3");
      bus.ready = 1'b0;
      strobe(1, 20'd5);
      tick();
      strobe_in = '0;
      tick();
      strobe(2, 20'd10);
      tick();
      strobe(2, 20'd20);
      tick();
      strobe_in = '0;
      bus.ready = 1'b1;
      tick();
      chk("ovr_rec", 32'(bus.data), 32'h0A200014);
`ifdef LIGHTHOUSE_ARB_OVERRUN_EN
      chk("ovr_one", 32'(overrun_count), 32'd1);
`else
      chk("ovr_one", 32'(overrun_count), 32'd0);
`endif
      tick();

      bus.ready = 1'b0;
      for (int k = 0; k < 5; k++) strobe(k * 3, AW'(k + 1));
      tick();
      strobe_in = '0;
      tick();
      bus.ready = 1'b1;
      tick();
      do_reset("mid");
      strobe(9, 20'hABCDE);
      tick();
      strobe_in = '0;
      tick();
      chk("post_rst", 32'(bus.data), 32'h0C1ABCDE);
      tick();

      bus.ready = 1'b0;
      for (int c = 0; c < 4500; c++) begin
         strobe_in = '1;
         for (int k = 0; k < S; k++) angle_in[k*AW +: AW] = AW'($urandom);
         tick();
      end
      strobe_in = '0;
`ifdef LIGHTHOUSE_ARB_OVERRUN_EN
      chk("sat", 32'(overrun_count), 32'h0000FFFF);
`else
      chk("sat", 32'(overrun_count), 32'd0);
`endif
      bus.ready = 1'b1;
      for (int c = 0; c < 20; c++) tick();

      for (int c = 0; c < 2000; c++) begin
         strobe_in = S'($urandom & $urandom & $urandom);
         for (int k = 0; k < S; k++) angle_in[k*AW +: AW] = AW'($urandom);
         bus.ready = ($urandom_range(0, 3) != 0);
         tick();
      end
      strobe_in = '0;
      bus.ready = 1'b1;
      for (int c = 0; c < 20; c++) tick();
      chk("final_drain", 32'(pending), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
